uart_rx_buffer: RTL and testbench

- Receive-side character buffer directly downstream of the UART receiver stage.
- Captures each finished character and its PE/FE/BI flags on the receiver's one-cycle finish strobe, and stores it in a 64-deep FIFO (16750 mode) or a single holding register (FIFO disabled).
- Presents the head entry to the register interface (RBR/LSR).
- Generates data-ready, overrun, FIFO-error, trigger-level and character-timeout indications for the interrupt logic.

---
 rtl/uart_rx_buffer.sv | 210 +++++++++++++++++++++
 tb/tb_uart_rx_buffer.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_buffer
// Purpose  : Receive-side character buffer behind the UART receiver. Captures
//            each finished character with its PE/FE/BI flags, stores it in a
//            DEPTH-entry FIFO (FIFOEN=1) or a single holding register
//            (FIFOEN=0), presents the head entry to RBR/LSR and produces the
//            data-ready, overrun, FIFO-error, trigger and timeout indications.
// Ports    : CLK, RSTN         clock / asynchronous active-low reset
//            RXCLK             16x baud enable tick
//            FIFOEN, CLEAR     FIFO mode select / RX FIFO reset pulse
//            RXTL              trigger level select
//            WLS, PEN, STB     character format (for timeout length)
//            WRITE, DIN, PE_IN, FE_IN, BI_IN   capture strobe and character
//            READ, LSRRD       RBR pop pulse / LSR read pulse
//            DOUT, PE, FE, BI  head entry
//            DR, OE, FIFOERR, COUNT, TRIGGER, TIMEOUT  status outputs
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_buffer #(
  parameter int ADDR_W = 6
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              RXCLK,
  input  logic              FIFOEN,
  input  logic              CLEAR,
  input  logic [1:0]        RXTL,
  input  logic [1:0]        WLS,
  input  logic              PEN,
  input  logic              STB,
  input  logic              WRITE,
  input  logic [7:0]        DIN,
  input  logic              PE_IN,
  input  logic              FE_IN,
  input  logic              BI_IN,
  input  logic              READ,
  input  logic              LSRRD,
  output logic [7:0]        DOUT,
  output logic              PE,
  output logic              FE,
  output logic              BI,
  output logic              DR,
  output logic              OE,
  output logic              FIFOERR,
  output logic [ADDR_W:0]   COUNT,
  output logic              TRIGGER,
  output logic              TIMEOUT
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int EW    = 11;  // {BI, FE, PE, DIN}

  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] TL_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] TL_QTR   = (ADDR_W+1)'(DEPTH / 4);
  localparam logic [ADDR_W:0] TL_HALF  = (ADDR_W+1)'(DEPTH / 2);
  localparam logic [ADDR_W:0] TL_HIGH  = (ADDR_W+1)'(DEPTH - 8);

  // Storage and state
  logic [EW-1:0]     mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   err_cnt;
  logic [9:0]        tcnt;
  logic              fifoen_q;
  logic              oe;
  logic [EW-1:0]     head;      // registered copy of the head entry

  // Datapath / control
  logic              clr;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic              overrun;
  logic              overwrite;
  logic              do_wr;
  logic              new_bad;
  logic              head_bad;
  logic [EW-1:0]     new_entry;
  logic [EW-1:0]     head_next;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_next;
  logic [ADDR_W-1:0] wr_next;
  logic [ADDR_W:0]   count_next;
  logic [ADDR_W:0]   err_next;
  logic [ADDR_W:0]   err_inc;
  logic [ADDR_W:0]   err_dec;
  logic [3:0]        char_bits;
  logic [9:0]        thresh;
  logic [9:0]        tcnt_next;
  logic [ADDR_W:0]   trig_lvl;

  assign new_entry = {BI_IN, FE_IN, PE_IN, DIN};
  assign new_bad   = BI_IN | FE_IN | PE_IN;
  // The head register always mirrors mem[rd_ptr] while the buffer holds data,
  // so it doubles as the read port for the error-counter bookkeeping.
  assign head_bad  = |head[10:8];

  // A mode change flushes the buffer just like an explicit FCR clear.
  assign clr   = CLEAR | (FIFOEN ^ fifoen_q);
  assign empty = (count == '0);
  assign full  = FIFOEN ? (count == FULL_CNT) : !empty;

  // When full, a same-cycle READ makes room, so the write is accepted.
  assign push      = !clr & WRITE & (!full | READ);
  assign pop       = !clr & READ & !empty;
  assign overrun   = !clr & WRITE & full & !READ;
  assign overwrite = overrun & !FIFOEN;
  assign do_wr     = push | overwrite;
  // The holding-register overwrite replaces the current head in place.
  assign wr_addr   = overwrite ? rd_ptr : wr_ptr;

  assign rd_next    = rd_ptr + {{(ADDR_W-1){1'b0}}, pop};
  assign wr_next    = wr_ptr + {{(ADDR_W-1){1'b0}}, push};
  assign count_next = count + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};

  assign err_inc  = {{ADDR_W{1'b0}}, do_wr & new_bad};
  assign err_dec  = {{ADDR_W{1'b0}}, (pop | overwrite) & head_bad};
  assign err_next = err_cnt + err_inc - err_dec;

  // Next head: hold when the buffer will be empty; bypass the memory when
  // the entry being written this cycle becomes the head.
  always_comb begin
    head_next = head;
    if (!clr && (count_next != '0)) begin
      if (do_wr && (wr_addr == rd_next)) begin
        head_next = new_entry;
      end else begin
        head_next = mem[rd_next];
      end
    end
  end

  // Character length 1 start + (5+WLS) data + PEN + 1 stop + STB; timeout is
  // four character times of 16x ticks = bits * 64.
  assign char_bits = 4'd7 + {2'b00, WLS} + {3'b000, PEN} + {3'b000, STB};
  assign thresh    = {char_bits, 6'b000000};

  always_comb begin
    tcnt_next = tcnt;
    if (clr || WRITE || READ || empty) begin
      tcnt_next = '0;
    end else if (RXCLK && FIFOEN && (tcnt < thresh)) begin
      tcnt_next = tcnt + 10'd1;
    end
  end

  always_comb begin
    trig_lvl = TL_ONE;
    case (RXTL)
      2'b00:   trig_lvl = TL_ONE;
      2'b01:   trig_lvl = TL_QTR;
      2'b10:   trig_lvl = TL_HALF;
      default: trig_lvl = TL_HIGH;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      err_cnt  <= '0;
      tcnt     <= '0;
      fifoen_q <= 1'b0;
      oe       <= 1'b0;
      head     <= '0;
    end else begin
      fifoen_q <= FIFOEN;
      head     <= head_next;
      tcnt     <= tcnt_next;
      // A same-cycle overrun beats the LSR read clear.
      oe       <= overrun | (oe & ~LSRRD);
      if (clr) begin
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        count   <= '0;
        err_cnt <= '0;
      end else begin
        rd_ptr  <= rd_next;
        wr_ptr  <= wr_next;
        count   <= count_next;
        err_cnt <= err_next;
      end
    end
  end

  // Character storage needs no reset: only entries below COUNT are ever read.
  always_ff @(posedge CLK) begin
    if (do_wr) begin
      mem[wr_addr] <= new_entry;
    end
  end

  assign DOUT    = head[7:0];
  assign PE      = head[8];
  assign FE      = head[9];
  assign BI      = head[10];
  assign DR      = !empty;
  assign OE      = oe;
  assign COUNT   = count;
  assign FIFOERR = FIFOEN & (err_cnt != '0);
  assign TRIGGER = FIFOEN & (count >= trig_lvl);
  assign TIMEOUT = FIFOEN & (tcnt == thresh);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_buffer
// Purpose  : Self-checking bench for uart_rx_buffer. Directed scenarios plus a
//            randomized run compared against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_buffer;

  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        RXCLK = 1'b0;
  logic        FIFOEN = 1'b1;
  logic        CLEAR = 1'b0;
  logic [1:0]  RXTL = 2'b00;
  logic [1:0]  WLS = 2'b11;
  logic        PEN = 1'b0;
  logic        STB = 1'b0;
  logic        WRITE = 1'b0;
  logic [7:0]  DIN = 8'h00;
  logic        PE_IN = 1'b0;
  logic        FE_IN = 1'b0;
  logic        BI_IN = 1'b0;
  logic        READ = 1'b0;
  logic        LSRRD = 1'b0;
  logic [7:0]  DOUT;
  logic        PE, FE, BI, DR, OE, FIFOERR, TRIGGER, TIMEOUT;
  logic [AW:0] COUNT;

  always #5 CLK = ~CLK;

  uart_rx_buffer #(.ADDR_W(AW)) dut (
    .CLK(CLK), .RSTN(RSTN), .RXCLK(RXCLK), .FIFOEN(FIFOEN), .CLEAR(CLEAR),
    .RXTL(RXTL), .WLS(WLS), .PEN(PEN), .STB(STB), .WRITE(WRITE), .DIN(DIN),
    .PE_IN(PE_IN), .FE_IN(FE_IN), .BI_IN(BI_IN), .READ(READ), .LSRRD(LSRRD),
    .DOUT(DOUT), .PE(PE), .FE(FE), .BI(BI), .DR(DR), .OE(OE),
    .FIFOERR(FIFOERR), .COUNT(COUNT), .TRIGGER(TRIGGER), .TIMEOUT(TIMEOUT)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of {BI,FE,PE,DIN} entries plus sticky state.
  logic [10:0] mq[$];
  logic        m_oe;
  logic        m_prev_en;
  logic [10:0] m_head;
  int          m_idle;

  function automatic int thr();
    return (1 + 5 + int'(WLS) + int'(PEN) + 1 + int'(STB)) * 64;
  endfunction

  function automatic int level();
    case (RXTL)
      2'b00:   return 1;
      2'b01:   return DEPTH / 4;
      2'b10:   return DEPTH / 2;
      default: return DEPTH - 8;
    endcase
  endfunction

  function automatic bit exp_err();
    bit any = 0;
    foreach (mq[i]) if (mq[i][10:8] != 3'b000) any = 1;
    return FIFOEN && any;
  endfunction

  function automatic bit exp_trig();
    return FIFOEN && (mq.size() >= level());
  endfunction

  function automatic bit exp_to();
    return FIFOEN && (m_idle == thr());
  endfunction

  task automatic model_reset();
    mq.delete();
    m_oe      = 1'b0;
    m_prev_en = 1'b0;
    m_head    = '0;
    m_idle    = 0;
  endtask

  // Apply the behavioural rules to the inputs present at the coming edge,
  // then advance one clock and settle 1 time unit after it.
  task automatic tick();
    bit clr, full, ovr, en;
    int cap;
    en  = FIFOEN;
    clr = CLEAR || (FIFOEN != m_prev_en);
    cap = en ? DEPTH : 1;
    ovr = 0;
    if (clr || WRITE || READ || mq.size() == 0) m_idle = 0;
    else if (RXCLK && en && m_idle < thr()) m_idle++;
    if (clr) begin
      mq.delete();
    end else begin
      full = (mq.size() >= cap);
      if (WRITE && full && !READ) begin
        ovr = 1;
        if (!en) mq[0] = {BI_IN, FE_IN, PE_IN, DIN};
      end else begin
        if (READ && mq.size() > 0) void'(mq.pop_front());
        if (WRITE) mq.push_back({BI_IN, FE_IN, PE_IN, DIN});
      end
    end
    if (ovr) m_oe = 1'b1;
    else if (LSRRD) m_oe = 1'b0;
    if (mq.size() > 0) m_head = mq[0];
    m_prev_en = en;
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input logic [2:0] flags);
    WRITE = 1'b1; DIN = d; {BI_IN, FE_IN, PE_IN} = flags;
    tick();
    WRITE = 1'b0; {BI_IN, FE_IN, PE_IN} = 3'b000;
  endtask

  task automatic rd();
    READ = 1'b1;
    tick();
    READ = 1'b0;
  endtask

  task automatic flush();
    CLEAR = 1'b1; LSRRD = 1'b1;
    tick();
    CLEAR = 1'b0; LSRRD = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if ({DOUT, PE, FE, BI, DR, OE, FIFOERR, COUNT, TRIGGER, TIMEOUT} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got DOUT=%h PE=%b FE=%b BI=%b DR=%b OE=%b FIFOERR=%b COUNT=%0d TRIG=%b TO=%b, want all 0",
               DOUT, PE, FE, BI, DR, OE, FIFOERR, COUNT, TRIGGER, TIMEOUT);
    end
    tick();  // mode-change detect after reset flushes once
    total++;
    if (COUNT !== 0 || DR !== 1'b0) begin
      bad++; $display("FAIL reset_idle: COUNT=%0d DR=%b want 0/0", COUNT, DR);
    end
  endtask

  task automatic test_order();
    logic [7:0] exp [3];
    exp[0] = 8'h41; exp[1] = 8'h42; exp[2] = 8'h43;
    flush();
    for (int i = 0; i < 3; i++) wr(exp[i], 3'b000);
    total++;
    if (COUNT !== 3) begin bad++; $display("FAIL order_count: COUNT=%0d want 3", COUNT); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (DOUT !== exp[i] || DR !== 1'b1) begin
        bad++; $display("FAIL order_dout%0d: DOUT=%h DR=%b want %h/1", i, DOUT, DR, exp[i]);
      end
      rd();
      total++;
      if (COUNT !== 7'(2 - i)) begin
        bad++; $display("FAIL order_cnt%0d: COUNT=%0d want %0d", i, COUNT, 2 - i);
      end
    end
    total++;
    if (DR !== 1'b0) begin bad++; $display("FAIL order_dr: DR=%b want 0", DR); end
  endtask

  task automatic test_overrun();
    logic [7:0] last;
    bit seen55;
    flush();
    for (int i = 0; i < DEPTH; i++) wr(8'(i), 3'b000);
    total++;
    if (COUNT !== 7'd64 || OE !== 1'b0) begin
      bad++; $display("FAIL full_fill: COUNT=%0d OE=%b want 64/0", COUNT, OE);
    end
    wr(8'h55, 3'b000);
    total++;
    if (COUNT !== 7'd64 || OE !== 1'b1) begin
      bad++; $display("FAIL overrun: COUNT=%0d OE=%b want 64/1", COUNT, OE);
    end
    LSRRD = 1'b1; tick(); LSRRD = 1'b0;
    total++;
    if (OE !== 1'b0) begin bad++; $display("FAIL oe_clear: OE=%b want 0", OE); end
    WRITE = 1'b1; READ = 1'b1; DIN = 8'hAA;
    tick();
    WRITE = 1'b0; READ = 1'b0;
    total++;
    if (COUNT !== 7'd64 || OE !== 1'b0 || DOUT !== 8'h01) begin
      bad++; $display("FAIL full_wr_rd: COUNT=%0d OE=%b DOUT=%h want 64/0/01", COUNT, OE, DOUT);
    end
    seen55 = 0;
    last = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      if (DOUT === 8'h55) seen55 = 1;
      last = DOUT;
      rd();
    end
    total++;
    if (seen55 || last !== 8'hAA || DR !== 1'b0) begin
      bad++; $display("FAIL drain: seen55=%b last=%h DR=%b want 0/aa/0", seen55, last, DR);
    end
  endtask

  task automatic test_fifoerr();
    flush();
    wr(8'h00, 3'b110);
    wr(8'h11, 3'b000);
    wr(8'h22, 3'b000);
    total++;
    if (FIFOERR !== 1'b1 || BI !== 1'b1 || FE !== 1'b1 || PE !== 1'b0) begin
      bad++; $display("FAIL fifoerr_set: FIFOERR=%b BI=%b FE=%b PE=%b want 1/1/1/0", FIFOERR, BI, FE, PE);
    end
    rd();
    total++;
    if (FIFOERR !== 1'b0 || BI !== 1'b0 || DOUT !== 8'h11) begin
      bad++; $display("FAIL fifoerr_clr: FIFOERR=%b BI=%b DOUT=%h want 0/0/11", FIFOERR, BI, DOUT);
    end
  endtask

  task automatic test_timeout(input logic [1:0] wls, input logic pen, input logic stb,
                              input int exp_ticks);
    int n;
    flush();
    WLS = wls; PEN = pen; STB = stb;
    wr(8'h33, 3'b000);
    RXCLK = 1'b1;
    n = 0;
    while (n < 1000) begin
      tick();
      n++;
      total++;
      if (TIMEOUT !== exp_to()) begin
        bad++; $display("FAIL timeout_track: tick %0d TIMEOUT=%b want %b", n, TIMEOUT, exp_to());
      end
      if (TIMEOUT === 1'b1) break;
    end
    total++;
    if (n != exp_ticks) begin
      bad++; $display("FAIL timeout_ticks: asserted after %0d ticks want %0d", n, exp_ticks);
    end
    rd();
    total++;
    if (TIMEOUT !== 1'b0) begin bad++; $display("FAIL timeout_read: TIMEOUT=%b want 0", TIMEOUT); end
    RXCLK = 1'b0;
  endtask

  task automatic test_trigger_mode();
    flush();
    RXTL = 2'b01;
    for (int i = 0; i < 15; i++) wr(8'(8'h80 + i), 3'b000);
    total++;
    if (TRIGGER !== 1'b0) begin bad++; $display("FAIL trig_15: TRIGGER=%b want 0", TRIGGER); end
    wr(8'h8F, 3'b000);
    total++;
    if (TRIGGER !== 1'b1) begin bad++; $display("FAIL trig_16: TRIGGER=%b want 1", TRIGGER); end
    FIFOEN = 1'b0;
    tick();
    total++;
    if (COUNT !== 0 || TRIGGER !== 1'b0 || DR !== 1'b0) begin
      bad++; $display("FAIL mode_clear: COUNT=%0d TRIG=%b DR=%b want 0/0/0", COUNT, TRIGGER, DR);
    end
    wr(8'h61, 3'b000);
    wr(8'h62, 3'b000);
    total++;
    if (DOUT !== 8'h62 || OE !== 1'b1 || COUNT !== 1) begin
      bad++; $display("FAIL holding_ovw: DOUT=%h OE=%b COUNT=%0d want 62/1/1", DOUT, OE, COUNT);
    end
    FIFOEN = 1'b1;
    flush();
  endtask

  task automatic test_random();
    int wp, rp;
    for (int c = 0; c < 4000; c++) begin
      case ((c / 400) % 4)
        0:       begin wp = 85; rp = 20; end
        1:       begin wp = 30; rp = 45; end
        2:       begin wp = 2;  rp = 1;  end
        default: begin wp = 50; rp = 50; end
      endcase
      WRITE = ($urandom_range(99) < wp);
      READ  = ($urandom_range(99) < rp);
      LSRRD = ($urandom_range(9) == 0);
      CLEAR = ($urandom_range(249) == 0);
      RXCLK = ($urandom_range(1) == 0) || ((c / 400) % 4 == 2);
      DIN   = 8'($urandom);
      PE_IN = ($urandom_range(7) == 0);
      FE_IN = ($urandom_range(7) == 0);
      BI_IN = ($urandom_range(15) == 0);
      if ($urandom_range(399) == 0) FIFOEN = ~FIFOEN;
      if ($urandom_range(49) == 0) RXTL = 2'($urandom);
      if ($urandom_range(199) == 0) begin
        WLS = 2'($urandom); PEN = 1'($urandom); STB = 1'($urandom);
      end
      tick();
      total++;
      if (COUNT !== 7'(mq.size()) || DR !== (mq.size() > 0)) begin
        bad++; $display("FAIL rnd_count c=%0d: COUNT=%0d DR=%b want %0d", c, COUNT, DR, mq.size());
      end
      total++;
      if ({BI, FE, PE, DOUT} !== m_head) begin
        bad++; $display("FAIL rnd_head c=%0d: got %h want %h", c, {BI, FE, PE, DOUT}, m_head);
      end
      total++;
      if (OE !== m_oe || FIFOERR !== exp_err()) begin
        bad++; $display("FAIL rnd_flags c=%0d: OE=%b FIFOERR=%b want %b/%b", c, OE, FIFOERR, m_oe, exp_err());
      end
      total++;
      if (TRIGGER !== exp_trig() || TIMEOUT !== exp_to()) begin
        bad++; $display("FAIL rnd_trig_to c=%0d: TRIG=%b TO=%b want %b/%b", c, TRIGGER, TIMEOUT, exp_trig(), exp_to());
      end
    end
    {WRITE, READ, LSRRD, CLEAR, RXCLK} = '0;
    FIFOEN = 1'b1;
    tick();
    flush();
  endtask

  task automatic test_async_reset();
    FIFOEN = 1'b1;
    flush();
    for (int i = 0; i <= DEPTH; i++) wr(8'(i + 3), 3'b001);
    for (int i = 0; i < DEPTH - 5; i++) rd();
    total++;
    if (COUNT !== 7'd5 || OE !== 1'b1) begin
      bad++; $display("FAIL arst_pre: COUNT=%0d OE=%b want 5/1", COUNT, OE);
    end
    #2;
    RSTN = 1'b0;
    #1;
    total++;
    if ({DOUT, PE, FE, BI, DR, OE, FIFOERR, COUNT, TRIGGER, TIMEOUT} !== '0) begin
      bad++;
      $display("FAIL arst_outputs: got DOUT=%h PE=%b FE=%b BI=%b DR=%b OE=%b FIFOERR=%b COUNT=%0d TRIG=%b TO=%b, want all 0",
               DOUT, PE, FE, BI, DR, OE, FIFOERR, COUNT, TRIGGER, TIMEOUT);
    end
    repeat (2) @(posedge CLK);
    #1;
    RSTN = 1'b1;
    model_reset();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    RSTN = 1'b1;
    test_reset();
    test_order();
    test_overrun();
    test_fifoerr();
    test_timeout(2'b11, 1'b0, 1'b0, 640);
    test_timeout(2'b00, 1'b1, 1'b1, 576);
    WLS = 2'b11; PEN = 1'b0; STB = 1'b0;
    test_trigger_mode();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
